// File: rtl/serial_add_scheduler.sv
// Round-robin front end for one bit-serial adder shared by two clients.
// Load, WIDTH shift cycles, then a single done cycle publishes the result.
module serial_add_scheduler #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             owner
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nx;
  logic [CNT_W-1:0] cnt;
  logic             c;
  logic             s;
  logic             cn;
  logic             rr;
  logic             pend;
  logic             go;
  logic             g;
  logic             last;

  assign s     = ra[0] ^ rb[0] ^ c;
  assign cn    = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
  assign sr_nx = {s, sr[WIDTH-1:1]};
  assign last  = (cnt == LAST);

  // Contention falls to rr; a lone request wins outright.
  assign g  = req[1] & (~req[0] | rr);
  assign go = (state == IDLE) && (req != 2'b00);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (go) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      sr    <= '0;
      cnt   <= '0;
      c     <= 1'b0;
      ack   <= 2'b00;
      pend  <= 1'b0;
      rr    <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      owner <= 1'b0;
    end else begin
      ack <= 2'b00;
      unique case (state)
        IDLE: begin
          if (go) begin
            ra   <= g ? a1 : a0;
            rb   <= g ? b1 : b0;
            c    <= 1'b0;
            cnt  <= '0;
            ack  <= g ? 2'b10 : 2'b01;
            pend <= g;
          end
        end
        SHIFT: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          c   <= cn;
          sr  <= sr_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            sum   <= sr_nx;
            cout  <= cn;
            owner <= pend;
          end
        end
        DONE: begin
          rr <= ~owner;
        end
        default: begin
          rr <= rr;
        end
      endcase
    end
  end

endmodule
